// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of a single-cycle CPU's data-memory port. The 8-bit byte
// address is decoded into word RAM and a small memory-mapped register block
// (LED, synchronised switches, free-running cycle counter, compare timer and
// a status register with write-1-to-clear flags).
//
// Loads are combinational so the CPU sees load data in the same cycle it
// presents the address. Stores commit on the rising clock edge. Every state
// update is gated by clk_enable. The one exception is the switch
// synchroniser, which samples on every clock.
//
// Ports
//   clk                rising-edge system clock
//   rst_n              asynchronous active-low reset
//   clk_enable         CPU step enable, gates all architectural state updates
//   mem_read_address   load byte address (addr[1:0] ignored)
//   mem_read_data      load data, combinational from the address decode
//   mem_write_address  store byte address (addr[1:0] ignored)
//   mem_write_data     store data
//   mem_write_enable   store strobe
//   sw_in              asynchronous switch inputs
//   led_out            LED register contents
//   timer_irq          sticky compare-match flag (STATUS[0])
//   bus_error          sticky unmapped-store flag (STATUS[1])
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int RAM_WORDS = 48,
  parameter int LED_WIDTH = 8,
  parameter int SW_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_enable,
  input  logic [7:0]           mem_read_address,
  output logic [31:0]          mem_read_data,
  input  logic [7:0]           mem_write_address,
  input  logic [31:0]          mem_write_data,
  input  logic                 mem_write_enable,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 timer_irq,
  output logic                 bus_error
);

  // Word indices (byte address / 4) of the register block.
  localparam logic [5:0] IDX_LED      = 6'd48;  // 0xC0
  localparam logic [5:0] IDX_SWITCH   = 6'd49;  // 0xC4
  localparam logic [5:0] IDX_CYCLE    = 6'd50;  // 0xC8
  localparam logic [5:0] IDX_CMP      = 6'd51;  // 0xCC
  localparam logic [5:0] IDX_STATUS   = 6'd52;  // 0xD0
  localparam logic [5:0] IDX_UNMAPPED = 6'd53;  // 0xD4 and above

  localparam int         RAM_AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [6:0] RAM_WORDS_L = 7'(RAM_WORDS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]          ram_q [RAM_WORDS];
  logic [LED_WIDTH-1:0] led_q,      led_d;
  logic [31:0]          cmp_q,      cmp_d;
  logic [31:0]          cycle_q,    cycle_d;
  logic                 match_q,    match_d;
  logic                 berr_q,     berr_d;
  logic [SW_WIDTH-1:0]  sw_meta_q,  sw_meta_d;
  logic [SW_WIDTH-1:0]  sw_sync_q,  sw_sync_d;

  logic [5:0] rd_idx;
  logic [5:0] wr_idx;
  logic       wr_fire;
  logic       rd_in_ram;
  logic       wr_in_ram;
  logic       ram_we;

  assign rd_idx    = mem_read_address[7:2];
  assign wr_idx    = mem_write_address[7:2];
  assign wr_fire   = mem_write_enable & clk_enable;
  assign rd_in_ram = ({1'b0, rd_idx} < RAM_WORDS_L);
  assign wr_in_ram = ({1'b0, wr_idx} < RAM_WORDS_L);
  // Stores to RAM words beyond RAM_WORDS (but still below 0xC0) fall out
  // here and are dropped without raising bus_error.
  assign ram_we    = wr_fire & wr_in_ram;

  // Byte-lane bits are ignored by the word-aligned decode.
  logic unused_bits;
  assign unused_bits = ^{mem_read_address[1:0], mem_write_address[1:0]};

  // ---------------------------------------------------------------------------
  // Load path: purely combinational, so a read-during-write to the same word
  // returns the pre-edge contents.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read_data = '0;
    if (rd_in_ram) begin
      mem_read_data = ram_q[rd_idx[RAM_AW-1:0]];
    end else begin
      case (rd_idx)
        IDX_LED:    mem_read_data = 32'(led_q);
        IDX_SWITCH: mem_read_data = 32'(sw_sync_q);
        IDX_CYCLE:  mem_read_data = cycle_q;
        IDX_CMP:    mem_read_data = cmp_q;
        IDX_STATUS: mem_read_data = {30'd0, berr_q, match_q};
        default:    mem_read_data = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    led_d     = led_q;
    cmp_d     = cmp_q;
    cycle_d   = cycle_q;
    match_d   = match_q;
    berr_d    = berr_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;

    if (clk_enable) begin
      cycle_d = cycle_q + 32'd1;
    end

    if (wr_fire) begin
      case (wr_idx)
        IDX_LED: led_d = mem_write_data[LED_WIDTH-1:0];
        IDX_CMP: cmp_d = mem_write_data;
        IDX_STATUS: begin
          if (mem_write_data[0]) match_d = 1'b0;
          if (mem_write_data[1]) berr_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Set terms come after the clears so a coincident set always wins.
    // The compare uses the pre-edge counter and CMP values.
    if (clk_enable && (cycle_q == cmp_q)) begin
      match_d = 1'b1;
    end
    if (wr_fire && (wr_idx >= IDX_UNMAPPED)) begin
      berr_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register block (asynchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      cmp_q     <= '0;
      cycle_q   <= '0;
      match_q   <= 1'b0;
      berr_q    <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      cmp_q     <= cmp_d;
      cycle_q   <= cycle_d;
      match_q   <= match_d;
      berr_q    <= berr_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word RAM: contents are never reset. A store presented while reset is
  // asserted is discarded so RAM keeps its last committed contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) begin
      ram_q[wr_idx[RAM_AW-1:0]] <= mem_write_data;
    end
  end

  assign led_out   = led_q;
  assign timer_irq = match_q;
  assign bus_error = berr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int RAM_WORDS = 16;
  localparam int LED_WIDTH = 8;
  localparam int SW_WIDTH  = 8;

  localparam int S_RD   = 0;
  localparam int S_LED  = 1;
  localparam int S_IRQ  = 2;
  localparam int S_BERR = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clk_enable;
  logic [7:0]           mem_read_address;
  logic [31:0]          mem_read_data;
  logic [7:0]           mem_write_address;
  logic [31:0]          mem_write_data;
  logic                 mem_write_enable;
  logic [SW_WIDTH-1:0]  sw_in;
  logic [LED_WIDTH-1:0] led_out;
  logic                 timer_irq;
  logic                 bus_error;

  data_mem_responder #(
    .RAM_WORDS(RAM_WORDS),
    .LED_WIDTH(LED_WIDTH),
    .SW_WIDTH (SW_WIDTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clk_enable       (clk_enable),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .sw_in            (sw_in),
    .led_out          (led_out),
    .timer_irq        (timer_irq),
    .bus_error        (bus_error)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int checks = 0;
  int errors = 0;

  // Scoreboard: expected values are queued by the stimulus and checked by
  // this monitor at the falling edge of the cycle they belong to.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc_cnt) begin
      c = q.pop_front();
      case (c.sel)
        S_RD:    act = mem_read_data;
        S_LED:   act = 32'(led_out);
        S_IRQ:   act = {31'd0, timer_irq};
        default: act = {31'd0, bus_error};
      endcase
      checks++;
      if (c.due != cyc_cnt || act !== c.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, due %0d)",
                 c.name, act, c.exp, cyc_cnt, c.due);
      end else begin
        $display("ok   %s: 0x%08h (cycle %0d)", c.name, act, cyc_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic we, input logic [7:0] wa,
                        input logic [31:0] wd, input logic [7:0] ra);
    clk_enable        = en;
    mem_write_enable  = we;
    mem_write_address = wa;
    mem_write_data    = wd;
    mem_read_address  = ra;
  endtask

  task automatic expect_val(input int sel, input logic [31:0] v, input string n);
    chk_t c;
    c.due  = cyc_cnt;
    c.sel  = sel;
    c.exp  = v;
    c.name = n;
    q.push_back(c);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = '0;
    set_in(1'b0, 1'b0, 8'h00, 32'h0, 8'hC8);
    tick();
    tick();
    expect_val(S_RD,   32'h0, "rst_cycle_rd");
    expect_val(S_LED,  32'h0, "rst_led");
    expect_val(S_IRQ,  32'h0, "rst_irq");
    expect_val(S_BERR, 32'h0, "rst_berr");
    tick();
    rst_n = 1'b1;

    // Timer: CYCLE=0 and CMP=0 out of reset, so the first enabled edge matches.
    set_in(1, 1, 8'hCC, 32'd5, 8'hC8); expect_val(S_RD, 32'd0, "cycle_start");     tick(); // E1
    set_in(1, 1, 8'hD0, 32'd1, 8'hCC); expect_val(S_RD, 32'd5, "cmp_rd");
    expect_val(S_IRQ, 32'd1, "irq_reset_match");                                    tick(); // E2 clear
    set_in(1, 0, 8'h00, 32'd0, 8'hC8); expect_val(S_IRQ, 32'd0, "irq_cleared");
    expect_val(S_RD, 32'd2, "cycle_2");                                             tick(); // E3
    tick();                                                                                 // E4
    expect_val(S_IRQ, 32'd0, "irq_before_e5");                                      tick(); // E5
    expect_val(S_RD, 32'd5, "cycle_5"); expect_val(S_IRQ, 32'd0, "irq_before_e6"); tick(); // E6 match
    set_in(1, 1, 8'hCC, 32'd9, 8'hD0); expect_val(S_IRQ, 32'd1, "irq_6th_edge");
    expect_val(S_RD, 32'd1, "status_match_bit");                                    tick(); // E7
    set_in(1, 1, 8'hD0, 32'd1, 8'hC8); expect_val(S_RD, 32'd7, "cycle_7");          tick(); // E8 clear
    set_in(1, 0, 8'h00, 32'd0, 8'hD0); expect_val(S_IRQ, 32'd0, "irq_clear2");      tick(); // E9
    set_in(1, 1, 8'hD0, 32'd1, 8'hD0); expect_val(S_IRQ, 32'd0, "irq_pre_race");    tick(); // E10 set+clear
    set_in(1, 1, 8'hD0, 32'd1, 8'hD0); expect_val(S_IRQ, 32'd1, "irq_set_wins");    tick(); // E11 clear
    set_in(1, 0, 8'h00, 32'd0, 8'hD0); expect_val(S_IRQ, 32'd0, "irq_clear_alone");
    expect_val(S_RD, 32'd0, "status_zero");                                         tick();

    // RAM
    set_in(1, 1, 8'h10, 32'hCAFEF00D, 8'h10);                                       tick();
    set_in(1, 1, 8'h14, 32'h0BADBEEF, 8'h13); expect_val(S_RD, 32'hCAFEF00D, "ram_rd_0x13"); tick();
    set_in(1, 1, 8'h10, 32'h00000011, 8'h10); expect_val(S_RD, 32'hCAFEF00D, "ram_rdw_old"); tick();
    set_in(1, 1, 8'h3C, 32'h12345678, 8'h10); expect_val(S_RD, 32'h00000011, "ram_rdw_new"); tick();
    set_in(0, 1, 8'h10, 32'h0000DEAD, 8'h3C); expect_val(S_RD, 32'h12345678, "ram_last_word"); tick();
    set_in(1, 0, 8'h00, 32'h0, 8'h10);        expect_val(S_RD, 32'h00000011, "ram_gated_store"); tick();
    set_in(1, 0, 8'h00, 32'h0, 8'h16);        expect_val(S_RD, 32'h0BADBEEF, "ram_word5"); tick();

    // LED
    set_in(1, 1, 8'hC0, 32'hFFFFFFA5, 8'hC0); expect_val(S_LED, 32'h0, "led_pre");  tick();
    set_in(0, 1, 8'hC0, 32'h0000005A, 8'hC0); expect_val(S_LED, 32'hA5, "led_a5");
    expect_val(S_RD, 32'h000000A5, "led_rd");                                       tick();
    set_in(1, 0, 8'h00, 32'h0, 8'hC0);        expect_val(S_LED, 32'hA5, "led_gated"); tick();

    // Bus error / out-of-range RAM / read-only registers
    set_in(1, 1, 8'hE0, 32'h1, 8'hE0);        expect_val(S_BERR, 32'd0, "berr_pre"); tick();
    set_in(1, 1, 8'hC4, 32'hFF, 8'hE0);       expect_val(S_BERR, 32'd1, "berr_set");
    expect_val(S_RD, 32'd0, "unmapped_rd");                                         tick();
    set_in(1, 1, 8'hD0, 32'h2, 8'hD0);        expect_val(S_RD, 32'd2, "status_berr");
    expect_val(S_BERR, 32'd1, "berr_ro_store");                                     tick();
    set_in(1, 1, 8'hBC, 32'h77, 8'hC4);       expect_val(S_BERR, 32'd0, "berr_clear");
    expect_val(S_RD, 32'd0, "sw_store_ignored");                                    tick();
    set_in(1, 0, 8'h00, 32'h0, 8'hBC);        expect_val(S_BERR, 32'd0, "berr_oob_ram");
    expect_val(S_RD, 32'd0, "ram_oob_rd");                                          tick();

    // Counter wrap
    set_in(1, 0, 8'h00, 32'h0, 8'hC8);
    force dut.cycle_q = 32'hFFFFFFFF;
    #1;
    release dut.cycle_q;
    expect_val(S_RD, 32'hFFFFFFFF, "cycle_forced");                                 tick();
    set_in(1, 1, 8'hCC, 32'd2, 8'hC8);        expect_val(S_RD, 32'd0, "cycle_wrap");
    expect_val(S_IRQ, 32'd0, "no_wrap_flag");                                       tick(); // cycle=1

    // Switch sync with clk_enable low
    set_in(0, 0, 8'h00, 32'h0, 8'hC4);
    sw_in = 8'h3C;
    expect_val(S_RD, 32'd0, "sw_pre");                                              tick();
    expect_val(S_RD, 32'd0, "sw_one_edge");                                         tick();
    expect_val(S_RD, 32'h3C, "sw_two_edges");                                       tick();
    set_in(1, 1, 8'hF0, 32'h0, 8'hC8);        expect_val(S_RD, 32'd1, "cycle_frozen"); tick(); // cycle=2, berr
    set_in(1, 0, 8'h00, 32'h0, 8'hC8);        expect_val(S_RD, 32'd2, "cycle_2b");   tick(); // match
    set_in(1, 0, 8'h00, 32'h0, 8'hC8);        expect_val(S_RD, 32'd3, "cycle_3b");
    expect_val(S_IRQ, 32'd1, "irq_pre_rst"); expect_val(S_BERR, 32'd1, "berr_pre_rst");
    expect_val(S_LED, 32'hA5, "led_pre_rst");                                       tick();

    // Asynchronous reset mid-cycle
    set_in(1, 1, 8'hC0, 32'hFF, 8'hC8);
    rst_n = 1'b0;
    expect_val(S_RD, 32'd0, "rst_async_cycle"); expect_val(S_LED, 32'd0, "rst_async_led");
    expect_val(S_IRQ, 32'd0, "rst_async_irq");  expect_val(S_BERR, 32'd0, "rst_async_berr");
    tick();
    expect_val(S_LED, 32'd0, "rst_store_lost");
    tick();
    rst_n = 1'b1;
    set_in(1, 0, 8'h00, 32'h0, 8'h10);        expect_val(S_RD, 32'h00000011, "ram_survives_rst");
    tick();

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d checks pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
